// File: rtl/bnn_weight_streamer_if.sv
// Host-side bus of the BNN nibble weight streamer.
//
// Handshake: load_en qualifies weight_nib on every cycle where it is high.
// The receiver has no backpressure, so each load_en=1 cycle is exactly one
// nibble consumed. hold is the host-side stall. start, wr_en and the pulse
// outputs (done, wr_rej) are single-cycle strobes. fsm_state is a debug view
// of the streamer FSM (0=IDLE, 1=LO, 2=HI, 3=DONE).
interface bnn_weight_streamer_if #(
  parameter int IDX_W = 5
);
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [7:0]       wr_data;
  logic             start;
  logic             hold;
  logic             busy;
  logic             done;
  logic             wr_rej;
  logic             load_en;
  logic [3:0]       weight_nib;
  logic [IDX_W-1:0] neuron_idx;
  logic [1:0]       fsm_state;

  modport master (
    output wr_en, wr_addr, wr_data, start, hold,
    input  busy, done, wr_rej, load_en, weight_nib, neuron_idx, fsm_state
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, hold,
    output busy, done, wr_rej, load_en, weight_nib, neuron_idx, fsm_state
  );
endinterface

// File: rtl/bnn_weight_streamer.sv
// bnn_weight_streamer: holds a shadow table of NUM_NEURONS weight bytes and
// streams it to the BNN core as {load_en, weight_nib} pairs, low nibble then
// high nibble per neuron.
//
// Optional feature macro BNN_STREAM_PAD_WRAP_EN: when defined, the stream is
// padded with zero pairs up to 2**IDX_W entries so the receiver's load
// counter wraps back to 0 and back-to-back reloads need no receiver reset.
module bnn_weight_streamer #(
  parameter int NUM_NEURONS = 12,
  parameter int IDX_W       = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  bnn_weight_streamer_if.slave bus
);

  localparam int AW = $clog2(NUM_NEURONS);
`ifdef BNN_STREAM_PAD_WRAP_EN
  localparam int LAST = (2 ** IDX_W) - 1;
`else
  localparam int LAST = NUM_NEURONS - 1;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);
  localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(NUM_NEURONS);
  localparam logic [4:0]       NUM_ADDR = 5'(NUM_NEURONS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Core power-on weight set, restored into the shadow table on reset.
  function automatic logic [7:0] power_on_weight(input int k);
    case (k)
      0:       return 8'hA0;
      1:       return 8'h41;
      2:       return 8'h7A;
      3:       return 8'h18;
      4:       return 8'hED;
      5:       return 8'hB7;
      6:       return 8'h67;
      7:       return 8'h3A;
      8:       return 8'hF9;
      9:       return 8'h62;
      10:      return 8'hF7;
      11:      return 8'h0F;
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0]       w_q [NUM_NEURONS];
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       nib_q, nib_d;
  logic             load_en_q, load_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rej_q, rej_d;
  // pend_q: current nibble was presented with load_en=0 (start under hold)
  // and still has to be sent once before the stream may advance.
  logic             pend_q, pend_d;
  // cur_q: byte of the entry in flight, so its high nibble matches its low one.
  logic [7:0]       cur_q, cur_d;

  logic             wr_ok;
  logic [IDX_W-1:0] next_idx;
  logic [7:0]       next_w;

  assign wr_ok    = bus.wr_en && !busy_q && ({1'b0, bus.wr_addr} < NUM_ADDR);
  assign next_idx = idx_q + IDX_W'(1);
  // Entries past the table (padding) stream as zero.
  assign next_w   = (next_idx < NUM_IDX) ? w_q[next_idx[AW-1:0]] : 8'h00;

  // Shadow table: reload power-on set on reset, accept writes only when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        w_q[k] <= power_on_weight(k);
      end
    end else if (wr_ok) begin
      w_q[bus.wr_addr[AW-1:0]] <= bus.wr_data;
    end
  end

  // FSM and output registers; reset drops load_en immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      nib_q     <= '0;
      load_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rej_q     <= 1'b0;
      pend_q    <= 1'b0;
      cur_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      nib_q     <= nib_d;
      load_en_q <= load_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rej_q     <= rej_d;
      pend_q    <= pend_d;
      cur_q     <= cur_d;
    end
  end

  // Next-state and next-output logic for the nibble stream.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nib_d     = nib_q;
    load_en_d = load_en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pend_d    = pend_q;
    cur_d     = cur_q;
    rej_d     = bus.wr_en && !wr_ok;

    case (state_q)
      S_IDLE: begin
        load_en_d = 1'b0;
        busy_d    = 1'b0;
        if (bus.start) begin
          state_d   = S_LO;
          idx_d     = '0;
          cur_d     = w_q[0];
          nib_d     = w_q[0][3:0];
          busy_d    = 1'b1;
          load_en_d = !bus.hold;
          pend_d    = bus.hold;
        end
      end
      S_LO: begin
        if (bus.hold) begin
          load_en_d = 1'b0;
        end else if (pend_q) begin
          load_en_d = 1'b1;
          pend_d    = 1'b0;
        end else begin
          state_d   = S_HI;
          nib_d     = cur_q[7:4];
          load_en_d = 1'b1;
        end
      end
      S_HI: begin
        if (bus.hold) begin
          load_en_d = 1'b0;
        end else if (idx_q == LAST_IDX) begin
          state_d   = S_DONE;
          idx_d     = '0;
          nib_d     = '0;
          load_en_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          state_d   = S_LO;
          idx_d     = next_idx;
          cur_d     = next_w;
          nib_d     = next_w[3:0];
          load_en_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.wr_rej     = rej_q;
  assign bus.load_en    = load_en_q;
  assign bus.weight_nib = nib_q;
  assign bus.neuron_idx = idx_q;
  assign bus.fsm_state  = state_q;

endmodule
